scale_ctrl: RTL and testbench



---
 rtl/scale_pkg.sv | 26 ++
 rtl/scale_ctrl_if.sv | 36 +++
 rtl/scale_ctrl_btn_edge.sv | 35 +++
 rtl/scale_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_scale_ctrl.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/scale_pkg.sv
// ============================================================================
// Module   : scale_pkg
// Brief    : Shared state encoding, widths and default limits for scale_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package scale_pkg;

    typedef enum logic [1:0] {
        S_ENTRY = 2'd0,
        S_ADD   = 2'd1,
        S_CAL   = 2'd2
    } state_e;

    localparam int W_WEIGHT = 4;
    localparam int W_PRICE  = 8;
    localparam int W_TIMES  = 8;
    localparam int W_SUM    = 16;

    localparam int SUM_MAX_DEF   = 9999;
    localparam int TIMES_MAX_DEF = 99;

endpackage

`default_nettype wire

// File: rtl/scale_ctrl_if.sv
// ============================================================================
// Module   : scale_ctrl_if
// Brief    : Button inputs and display-facing outputs of the price-scale core.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface scale_ctrl_if;
    import scale_pkg::*;

    logic                btn_weight;
    logic                btn_per;
    logic                btn_add;
    logic                btn_cal;
    logic                btn_clr;
    logic [W_WEIGHT-1:0] weight;
    logic [W_WEIGHT-1:0] per;
    logic [W_PRICE-1:0]  price;
    logic [W_TIMES-1:0]  times;
    logic [W_SUM-1:0]    sum;
    logic                state_cal;
    logic                overflow;

    modport slave (
        input  btn_weight, btn_per, btn_add, btn_cal, btn_clr,
        output weight, per, price, times, sum, state_cal, overflow
    );

    modport master (
        output btn_weight, btn_per, btn_add, btn_cal, btn_clr,
        input  weight, per, price, times, sum, state_cal, overflow
    );

endinterface

`default_nettype wire

// File: rtl/scale_ctrl_btn_edge.sv
// ============================================================================
// Module   : btn_edge
// Brief    : Registered rising-edge detector; the history flop resets high so
//            a button held through reset does not fire on release.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_edge (
    input  wire logic clk,
    input  wire logic state_reset,
    input  wire logic i_btn,
    output logic      o_rise
);

    logic btn_q;
    logic btn_d;

    always_comb begin
        btn_d = i_btn;
    end

    always_ff @(posedge clk) begin
        if (state_reset) begin
            btn_q <= 1'b1;
        end else begin
            btn_q <= btn_d;
        end
    end

    assign o_rise = i_btn & ~btn_q;

endmodule

`default_nettype wire

// File: rtl/scale_ctrl.sv
// ============================================================================
// Module   : scale_ctrl
// Brief    : Price-scale sequencer: button edges drive weight/per entry, item
//            commit into saturating totals, and the ENTRY/CAL display mode.
//            Optional CAL idle auto-return: SCALE_CTRL_AUTO_RETURN_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module scale_ctrl
    import scale_pkg::*;
#(
    parameter int MAX_WEIGHT = 15,
    parameter int MAX_PER    = 15,
    parameter int TIMES_MAX  = TIMES_MAX_DEF,
    parameter int SUM_MAX    = SUM_MAX_DEF
`ifdef SCALE_CTRL_AUTO_RETURN_EN
    ,
    parameter int CAL_TIMEOUT = 50_000_000
`endif
) (
    input  wire logic   clk,
    input  wire logic   state_reset,
    scale_ctrl_if.slave bus
);

    localparam logic [W_WEIGHT-1:0] c_max_weight = W_WEIGHT'(MAX_WEIGHT);
    localparam logic [W_WEIGHT-1:0] c_max_per    = W_WEIGHT'(MAX_PER);
    localparam logic [W_TIMES-1:0]  c_times_max  = W_TIMES'(TIMES_MAX);
    localparam logic [W_SUM-1:0]    c_sum_max    = W_SUM'(SUM_MAX);
    localparam logic [W_SUM:0]      c_sum_max_x  = (W_SUM+1)'(SUM_MAX);

    // Bit order: 0 weight, 1 per, 2 add, 3 cal, 4 clr
    logic [4:0] w_btn;
    logic [4:0] w_rise;

    assign w_btn = {bus.btn_clr, bus.btn_cal, bus.btn_add, bus.btn_per, bus.btn_weight};

    for (genvar gi = 0; gi < 5; gi++) begin : g_edge
        btn_edge u_btn_edge (
            .clk         (clk),
            .state_reset (state_reset),
            .i_btn       (w_btn[gi]),
            .o_rise      (w_rise[gi])
        );
    end

    state_e              state_q,     state_d;
    logic [W_WEIGHT-1:0] weight_q,    weight_d;
    logic [W_WEIGHT-1:0] per_q,       per_d;
    logic [W_PRICE-1:0]  price_q,     price_d;
    logic [W_TIMES-1:0]  times_q,     times_d;
    logic [W_SUM-1:0]    sum_q,       sum_d;
    logic                overflow_q,  overflow_d;
    logic                state_cal_q, state_cal_d;

    logic [W_PRICE-1:0]  w_product;
    logic [W_SUM:0]      w_sum_ext;

    assign w_product = W_PRICE'(weight_q) * W_PRICE'(per_q);
    assign w_sum_ext = {1'b0, sum_q} + (W_SUM+1)'(w_product);

`ifdef SCALE_CTRL_AUTO_RETURN_EN
    localparam logic [25:0] c_timeout_last = 26'(CAL_TIMEOUT - 1);

    logic [25:0] idle_q, idle_d;
    logic        w_timeout;

    // Counts only while parked in CAL with no button activity.
    always_comb begin
        idle_d = '0;
        if (state_q == S_CAL && w_rise == 5'b0) begin
            idle_d = idle_q + 26'd1;
        end
    end

    assign w_timeout = (state_q == S_CAL) && (w_rise == 5'b0) && (idle_q == c_timeout_last);

    always_ff @(posedge clk) begin
        if (state_reset) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    logic w_timeout;
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        weight_d   = weight_q;
        per_d      = per_q;
        times_d    = times_q;
        sum_d      = sum_q;
        overflow_d = overflow_q;
        price_d    = w_product;

        case (state_q)
            S_ENTRY: begin
                if (w_rise[4]) begin
                    weight_d = '0;
                    per_d    = '0;
                end else if (w_rise[3]) begin
                    state_d = S_CAL;
                end else if (w_rise[2] && w_product != '0) begin
                    state_d = S_ADD;
                end else begin
                    // A zero-product add is treated as absent, so entry edges still apply.
                    if (w_rise[0]) begin
                        weight_d = (weight_q == c_max_weight) ? '0 : weight_q + 1'b1;
                    end
                    if (w_rise[1]) begin
                        per_d = (per_q == c_max_per) ? '0 : per_q + 1'b1;
                    end
                end
            end
            S_ADD: begin
                if (w_sum_ext > c_sum_max_x) begin
                    sum_d      = c_sum_max;
                    overflow_d = 1'b1;
                end else begin
                    sum_d = w_sum_ext[W_SUM-1:0];
                end
                times_d  = (times_q >= c_times_max) ? c_times_max : times_q + 1'b1;
                weight_d = '0;
                per_d    = '0;
                state_d  = S_ENTRY;
            end
            S_CAL: begin
                if (w_rise[4]) begin
                    times_d    = '0;
                    sum_d      = '0;
                    overflow_d = 1'b0;
                    state_d    = S_ENTRY;
                end else if (w_rise[3] || w_timeout) begin
                    state_d = S_ENTRY;
                end
            end
            default: begin
                state_d = S_ENTRY;
            end
        endcase

        state_cal_d = (state_d == S_CAL);
    end

    always_ff @(posedge clk) begin
        if (state_reset) begin
            state_q     <= S_ENTRY;
            weight_q    <= '0;
            per_q       <= '0;
            price_q     <= '0;
            times_q     <= '0;
            sum_q       <= '0;
            overflow_q  <= 1'b0;
            state_cal_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            weight_q    <= weight_d;
            per_q       <= per_d;
            price_q     <= price_d;
            times_q     <= times_d;
            sum_q       <= sum_d;
            overflow_q  <= overflow_d;
            state_cal_q <= state_cal_d;
        end
    end

    assign bus.weight    = weight_q;
    assign bus.per       = per_q;
    assign bus.price     = price_q;
    assign bus.times     = times_q;
    assign bus.sum       = sum_q;
    assign bus.overflow  = overflow_q;
    assign bus.state_cal = state_cal_q;

endmodule

`default_nettype wire

// File: tb/tb_scale_ctrl.sv
// ============================================================================
// Module   : tb_scale_ctrl
// Brief    : Self-checking bench for scale_ctrl: directed vector table, corner
//            sequences and randomized button traffic against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scale_ctrl;

    localparam logic [4:0] BW = 5'b00001;
    localparam logic [4:0] BP = 5'b00010;
    localparam logic [4:0] BA = 5'b00100;
    localparam logic [4:0] BC = 5'b01000;
    localparam logic [4:0] BX = 5'b10000;
    localparam logic [4:0] B0 = 5'b00000;

    logic clk = 1'b0;
    logic state_reset;

    always #5 clk = ~clk;

    scale_ctrl_if bus();

    scale_ctrl #(
        .MAX_WEIGHT (15),
        .MAX_PER    (15),
        .TIMES_MAX  (99),
        .SUM_MAX    (9999)
    ) dut (
        .clk         (clk),
        .state_reset (state_reset),
        .bus         (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: mode 0 = entry, 1 = commit pending, 2 = totals view
    int         m_w, m_p, m_price, m_times, m_sum, m_ovf, m_cal, m_mode;
    logic [4:0] m_prev;

    function automatic void model_step(input logic rst, input logic [4:0] b);
        logic [4:0] e;
        int prod;
        if (rst) begin
            m_w = 0; m_p = 0; m_price = 0; m_times = 0; m_sum = 0;
            m_ovf = 0; m_cal = 0; m_mode = 0; m_prev = 5'b11111;
            return;
        end
        e = b & ~m_prev;
        m_prev = b;
        prod = m_w * m_p;
        m_price = prod;
        case (m_mode)
            1: begin
                if (m_sum + prod > 9999) begin
                    m_sum = 9999;
                    m_ovf = 1;
                end else begin
                    m_sum = m_sum + prod;
                end
                m_times = (m_times + 1 > 99) ? 99 : m_times + 1;
                m_w = 0; m_p = 0; m_mode = 0;
            end
            2: begin
                if (e[4]) begin
                    m_times = 0; m_sum = 0; m_ovf = 0; m_mode = 0;
                end else if (e[3]) begin
                    m_mode = 0;
                end
            end
            default: begin
                if (e[4]) begin
                    m_w = 0; m_p = 0;
                end else if (e[3]) begin
                    m_mode = 2;
                end else if (e[2] && prod != 0) begin
                    m_mode = 1;
                end else begin
                    if (e[0]) m_w = (m_w + 1) % 16;
                    if (e[1]) m_p = (m_p + 1) % 16;
                end
            end
        endcase
        m_cal = (m_mode == 2) ? 1 : 0;
    endfunction

    task automatic cyc(input logic rst, input logic [4:0] b);
        @(negedge clk);
        state_reset    = rst;
        bus.btn_weight = b[0];
        bus.btn_per    = b[1];
        bus.btn_add    = b[2];
        bus.btn_cal    = b[3];
        bus.btn_clr    = b[4];
        @(posedge clk);
        model_step(rst, b);
        #1;
    endtask

    task automatic check_exp(input string name, input int w, input int p, input int pr,
                             input int t, input int s, input int c, input int o);
        logic [41:0] got, exp;
        got = {bus.weight, bus.per, bus.price, bus.times, bus.sum, bus.state_cal, bus.overflow};
        exp = {4'(w), 4'(p), 8'(pr), 8'(t), 16'(s), 1'(c), 1'(o)};
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got w=%0d p=%0d price=%0d times=%0d sum=%0d cal=%0d ovf=%0d, expected w=%0d p=%0d price=%0d times=%0d sum=%0d cal=%0d ovf=%0d",
                     name, bus.weight, bus.per, bus.price, bus.times, bus.sum, bus.state_cal,
                     bus.overflow, w, p, pr, t, s, c, o);
        end
    endtask

    task automatic check_model(input string name);
        check_exp(name, m_w, m_p, m_price, m_times, m_sum, m_cal, m_ovf);
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc_chk(input string name, input logic rst, input logic [4:0] b);
        cyc(rst, b);
        check_model(name);
    endtask

    typedef struct {
        logic       rst;
        logic [4:0] btn;
        int w, p, price, times, sum, cal, ovf;
    } vec_t;

    vec_t tbl[35];

    initial begin
        state_reset    = 1'b1;
        bus.btn_weight = 1'b0;
        bus.btn_per    = 1'b0;
        bus.btn_add    = 1'b0;
        bus.btn_cal    = 1'b0;
        bus.btn_clr    = 1'b0;
        model_step(1'b1, B0);

        //         rst   btn      w  p  pr t  s   c  o
        tbl[0]  = '{1'b1, B0,      0, 0, 0, 0, 0,  0, 0};
        tbl[1]  = '{1'b0, B0,      0, 0, 0, 0, 0,  0, 0};
        tbl[2]  = '{1'b0, BW,      1, 0, 0, 0, 0,  0, 0};
        tbl[3]  = '{1'b0, B0,      1, 0, 0, 0, 0,  0, 0};
        tbl[4]  = '{1'b0, BW,      2, 0, 0, 0, 0,  0, 0};
        tbl[5]  = '{1'b0, B0,      2, 0, 0, 0, 0,  0, 0};
        tbl[6]  = '{1'b0, BW,      3, 0, 0, 0, 0,  0, 0};
        tbl[7]  = '{1'b0, BP,      3, 1, 0, 0, 0,  0, 0};
        tbl[8]  = '{1'b0, B0,      3, 1, 3, 0, 0,  0, 0};
        tbl[9]  = '{1'b0, BP,      3, 2, 3, 0, 0,  0, 0};
        tbl[10] = '{1'b0, B0,      3, 2, 6, 0, 0,  0, 0};
        tbl[11] = '{1'b0, BP,      3, 3, 6, 0, 0,  0, 0};
        tbl[12] = '{1'b0, B0,      3, 3, 9, 0, 0,  0, 0};
        tbl[13] = '{1'b0, BP,      3, 4, 9, 0, 0,  0, 0};
        tbl[14] = '{1'b0, B0,      3, 4, 12, 0, 0, 0, 0};
        tbl[15] = '{1'b0, BA,      3, 4, 12, 0, 0, 0, 0};
        tbl[16] = '{1'b0, B0,      0, 0, 12, 1, 12, 0, 0};
        tbl[17] = '{1'b0, B0,      0, 0, 0, 1, 12, 0, 0};
        tbl[18] = '{1'b0, BW,      1, 0, 0, 1, 12, 0, 0};
        tbl[19] = '{1'b0, B0,      1, 0, 0, 1, 12, 0, 0};
        tbl[20] = '{1'b0, BW,      2, 0, 0, 1, 12, 0, 0};
        tbl[21] = '{1'b0, BP,      2, 1, 0, 1, 12, 0, 0};
        tbl[22] = '{1'b0, B0,      2, 1, 2, 1, 12, 0, 0};
        tbl[23] = '{1'b0, BP,      2, 2, 2, 1, 12, 0, 0};
        tbl[24] = '{1'b0, B0,      2, 2, 4, 1, 12, 0, 0};
        tbl[25] = '{1'b0, BP,      2, 3, 4, 1, 12, 0, 0};
        tbl[26] = '{1'b0, B0,      2, 3, 6, 1, 12, 0, 0};
        tbl[27] = '{1'b0, BX | BA, 0, 0, 6, 1, 12, 0, 0};
        tbl[28] = '{1'b0, B0,      0, 0, 0, 1, 12, 0, 0};
        tbl[29] = '{1'b0, BC,      0, 0, 0, 1, 12, 1, 0};
        tbl[30] = '{1'b0, B0,      0, 0, 0, 1, 12, 1, 0};
        tbl[31] = '{1'b0, BW,      0, 0, 0, 1, 12, 1, 0};
        tbl[32] = '{1'b0, B0,      0, 0, 0, 1, 12, 1, 0};
        tbl[33] = '{1'b0, BX,      0, 0, 0, 0, 0,  0, 0};
        tbl[34] = '{1'b0, B0,      0, 0, 0, 0, 0,  0, 0};

        for (int i = 0; i < 35; i++) begin
            cyc(tbl[i].rst, tbl[i].btn);
            check_exp($sformatf("table[%0d]", i), tbl[i].w, tbl[i].p, tbl[i].price,
                      tbl[i].times, tbl[i].sum, tbl[i].cal, tbl[i].ovf);
        end

        // Weight wrap with per=1 so price mirrors weight one cycle late.
        cyc_chk("wrap_rst", 1'b1, B0);
        cyc_chk("wrap_idle", 1'b0, B0);
        cyc_chk("wrap_per", 1'b0, BP);
        cyc_chk("wrap_per_rel", 1'b0, B0);
        for (int k = 1; k <= 16; k++) begin
            cyc_chk("wrap_press", 1'b0, BW);
            check_val($sformatf("wrap_weight[%0d]", k), int'(bus.weight), k % 16);
            cyc_chk("wrap_rel", 1'b0, B0);
            check_val($sformatf("wrap_price[%0d]", k), int'(bus.price), k % 16);
        end

        // Saturation: 45 commits of 15*15 = 225.
        cyc_chk("sat_rst", 1'b1, B0);
        cyc_chk("sat_idle", 1'b0, B0);
        for (int k = 1; k <= 45; k++) begin
            for (int j = 0; j < 15; j++) begin
                cyc_chk("sat_wp", 1'b0, BW | BP);
                cyc_chk("sat_wp_rel", 1'b0, B0);
            end
            if (k == 1) begin
                check_val("sat_weight15", int'(bus.weight), 15);
                check_val("sat_per15", int'(bus.per), 15);
            end
            cyc_chk("sat_add", 1'b0, BA);
            cyc_chk("sat_commit", 1'b0, B0);
            if (k == 44) begin
                check_val("sum_after_44", int'(bus.sum), 9900);
                check_val("ovf_after_44", int'(bus.overflow), 0);
            end
            if (k == 45) begin
                check_val("sum_after_45", int'(bus.sum), 9999);
                check_val("ovf_after_45", int'(bus.overflow), 1);
                check_val("times_after_45", int'(bus.times), 45);
            end
        end

        // Reset landing on the ADD cycle, add held through release.
        cyc_chk("radd_rst", 1'b1, B0);
        cyc_chk("radd_idle", 1'b0, B0);
        for (int j = 0; j < 3; j++) begin
            cyc_chk("radd_p", 1'b0, (j < 2) ? (BW | BP) : BP);
            cyc_chk("radd_rel", 1'b0, B0);
        end
        check_val("radd_weight", int'(bus.weight), 2);
        check_val("radd_per", int'(bus.per), 3);
        cyc_chk("radd_add", 1'b0, BA);
        cyc_chk("radd_reset_in_add", 1'b1, BA);
        check_exp("radd_all_zero", 0, 0, 0, 0, 0, 0, 0);
        for (int j = 0; j < 3; j++) cyc_chk("radd_hold", 1'b0, BA);
        check_val("radd_times", int'(bus.times), 0);
        check_val("radd_sum", int'(bus.sum), 0);
        cyc_chk("radd_release", 1'b0, B0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [4:0] b;
            logic       r;
            for (int j = 0; j < 5; j++) b[j] = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) b[4:3] = 2'b00;
            r = ($urandom_range(0, 199) == 0);
            cyc_chk("random", r, b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
